// File: rtl/loop_nest_controller.sv
// Two-level loop sequencer driving an external 8-bit ring counter as the inner (column) loop.
// Optional build macro LOOP_NEST_STALL_EN adds a stall_i input that freezes the sweep in RUN.
module loop_nest_controller #(
  parameter int CNT_W  = 8,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              abort_i,
`ifdef LOOP_NEST_STALL_EN
  input  logic              stall_i,
`endif
  input  logic [CNT_W-1:0]  i_num_col,
  input  logic [CNT_W-1:0]  i_num_row,
  input  logic [ADDR_W-1:0] i_base_addr,
  input  logic [CNT_W-1:0]  cnt_i,
  input  logic              cnt_done_i,
  output logic              cnt_en_o,
  output logic [CNT_W-1:0]  cnt_num_o,
  output logic              cnt_clr_o,
  output logic              busy_o,
  output logic              valid_o,
  output logic [CNT_W-1:0]  row_o,
  output logic [CNT_W-1:0]  col_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic              done_o
);

  // Handshake: start_i is accepted only in IDLE; busy_o stays high for the whole
  // RUN phase; done_o pulses for one cycle after the last valid beat. An abort
  // drops back to IDLE without a done_o pulse.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  row_q;
  logic [CNT_W-1:0]  col_q;
  logic [CNT_W-1:0]  row_lim_q;
  logic [ADDR_W-1:0] addr_q;
  logic              stall;
  logic              run_active;
  logic              last_row;

`ifdef LOOP_NEST_STALL_EN
  assign stall = stall_i;
`else
  assign stall = 1'b0;
`endif

  assign run_active = (state_q == RUN) && !stall;
  assign last_row   = (row_q == row_lim_q);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start_i) state_d = RUN;
      RUN: begin
        // Abort wins over a coincident done; the counter's done is gated by
        // its enable, but qualify with run_active anyway so a stall never advances.
        if (abort_i)                                    state_d = IDLE;
        else if (run_active && cnt_done_i && last_row)  state_d = FIN;
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      row_q     <= '0;
      col_q     <= '0;
      row_lim_q <= '0;
      addr_q    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && start_i) begin
        col_q     <= i_num_col;
        row_lim_q <= i_num_row;
        addr_q    <= i_base_addr;
        row_q     <= '0;
      end else if (run_active) begin
        addr_q <= addr_q + 1'b1;
        if (cnt_done_i && !last_row) row_q <= row_q + 1'b1;
      end
    end
  end

  // Counter is held in clear whenever no run is active, so every run starts at column 0.
  assign cnt_clr_o = ~rst | (state_q == IDLE);
  assign cnt_en_o  = run_active;
  assign cnt_num_o = col_q;
  assign busy_o    = (state_q == RUN);
  assign valid_o   = run_active;
  assign row_o     = row_q;
  assign col_o     = cnt_i;
  assign addr_o    = addr_q;
  assign done_o    = (state_q == FIN);

endmodule

// File: doc/loop_nest_controller.md
Name: loop_nest_controller

Overview:
- Two-level loop sequencer that sits directly upstream of the 8-bit ring counter (clk/rst/en/i_num_cnt -> cnt_o/done_o).
- Drives the counter's enable and terminal count as the inner (column) loop, and consumes its count and done pulse.
- Counts done pulses as the outer (row) loop and generates a linear address stream for the downstream datapath.
- Uses a start/busy/done handshake toward the top-level control FSM.

Parameters:
- CNT_W, 8, width of row/column counts; matches ring counter width.
- ADDR_W, 16, width of generated linear address.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous active-low reset.
- start_i  input  1  start request; sampled in IDLE only.
- abort_i  input  1  abort current run; honoured in RUN only.
- i_num_col  input  CNT_W  inner terminal count C; column runs 0..C.
- i_num_row  input  CNT_W  outer terminal count R; row runs 0..R.
- i_base_addr  input  ADDR_W  start address of the sweep.
- cnt_i  input  CNT_W  ring counter cnt_o.
- cnt_done_i  input  1  ring counter done_o.
- cnt_en_o  output  1  ring counter en.
- cnt_num_o  output  CNT_W  ring counter i_num_cnt; equals latched C.
- cnt_clr_o  output  1  positive clear for ring counter rst.
- busy_o  output  1  high in RUN.
- valid_o  output  1  row_o/col_o/addr_o valid this cycle.
- row_o  output  CNT_W  current row index.
- col_o  output  CNT_W  current column index; equals cnt_i.
- addr_o  output  ADDR_W  current linear address.
- done_o  output  1  one-cycle pulse at normal completion.

Behaviour:
- Reset (rst=0 at rising edge): state=IDLE, row_q=0, addr_q=0, col_q=0, row_lim_q=0, done_o=0.
- cnt_clr_o = ~rst OR (state==IDLE). The external counter is therefore held at 0 whenever no run is active.
- States: IDLE, RUN, FIN.
- IDLE:
  - busy_o=0, valid_o=0, cnt_en_o=0.
  - On start_i=1: latch C->col_q, R->row_lim_q, i_base_addr->addr_q; set row_q=0; go RUN.
  - abort_i is ignored in IDLE.
- RUN:
  - busy_o=1, cnt_en_o=1, valid_o=1.
  - row_o=row_q, col_o=cnt_i, addr_o=addr_q.
  - Each cycle: addr_q <= addr_q+1, wrapping modulo 2^ADDR_W with no flag.
  - On cnt_done_i=1:
    - if row_q==row_lim_q, go FIN;
    - else row_q <= row_q+1.
  - start_i is ignored while busy.
- FIN:
  - done_o=1 for exactly one cycle; valid_o=0, cnt_en_o=0; next state IDLE.
- cnt_num_o = col_q at all times; stable during RUN even if i_num_col changes.
- Latency:
  - start_i sampled at edge N -> first valid_o in cycle N+1.
  - Exactly (R+1)*(C+1) consecutive valid cycles.
  - done_o in the cycle after the last valid cycle.
  - Earliest accepted restart is the edge after FIN.
- Edge cases:
  - C=0: cnt_done_i every cycle; one valid cycle per row.
  - R=0, C=0: one valid cycle, then done_o.
  - R=C=255: 65536 valid cycles; row_q never overflows.
- cnt_done_i outside RUN is ignored.
- abort_i=1 in RUN:
  - next state IDLE, no done_o;
  - cnt_clr_o asserts from the next cycle, returning the counter to 0;
  - abort has priority over a coincident cnt_done_i.
- rst=0 mid-run: immediate return to reset state at that edge; no done_o.

Optional Feature:
- Macro LOOP_NEST_STALL_EN.
- Defined:
  - Adds input stall_i (1 bit).
  - In RUN with stall_i=1: cnt_en_o=0, valid_o=0, addr_q/row_q hold. The counter's done is gated by its en, so no row advance occurs.
  - Stall has no effect in IDLE/FIN.
  - abort_i overrides stall.
- Not defined: port absent; RUN never stalls.

Test Plan:
- Reset with rst=0 for 2 cycles -> all outputs 0, cnt_clr_o=1.
- start with C=3, R=1, base=0x0100 -> 8 valid cycles:
  - (row,col) = (0,0..3) then (1,0..3);
  - addr 0x0100..0x0107;
  - done_o one cycle later; counter back at 0.
- C=0, R=0, base=0xFFFF -> single valid cycle addr 0xFFFF; next run from base 0x0000 starts clean.
- abort_i on 3rd valid cycle of C=5, R=2 -> no done_o; cnt_clr_o=1 next cycle; new start gives (0,0) first.
- start_i held high through a C=2, R=0 run, and i_num_col changed mid-run -> exactly one run; cnt_num_o stays 2; a new run starts the edge after FIN.
- With LOOP_NEST_STALL_EN: stall_i high 4 cycles mid C=3, R=1 run -> still 8 valid cycles total; addr sequence contiguous; done_o delayed by exactly 4 cycles.
